// File: rtl/pixel_seq_pkg.sv
// Shared types and default timing for the pixel sequencing controller.
// State order matters: it follows the physical frame sequence.
package pixel_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERASE   = 3'd1,
        EXPOSE  = 3'd2,
        CONVERT = 3'd3,
        READ1   = 3'd4,
        READ2   = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam int DEF_ERASE_CYCLES = 5;
    localparam int DEF_CONV_CYCLES  = 255;
    localparam int DEF_READ_CYCLES  = 2;

endpackage

// File: rtl/pixel_seq_ctrl_phase_timer.sv
// 8-bit load/count-down phase timer. done is high while the count sits at zero,
// so loading N-1 on state entry makes that state last exactly N cycles.
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == 8'd0);

endmodule

// File: rtl/pixel_seq_ctrl.sv
// Frame sequencer for a pixel array: erase, expose, gray-ramp convert, two row reads.
// Outputs are registered decodes of the next state, so they change with the state itself.
module pixel_seq_ctrl
    import pixel_seq_pkg::*;
#(
    parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
    parameter int CONV_CYCLES  = DEF_CONV_CYCLES,
    parameter int READ_CYCLES  = DEF_READ_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] exp_time,
    output logic       erase,
    output logic       expose,
    output logic       convert,
    output logic       read1,
    output logic       read2,
    output logic       busy,
    output logic       frame_done,
    output state_t     state
);

    localparam logic [7:0] ERASE_LOAD = 8'(ERASE_CYCLES - 1);
    localparam logic [7:0] CONV_LOAD  = 8'(CONV_CYCLES - 1);
    localparam logic [7:0] READ_LOAD  = 8'(READ_CYCLES - 1);

    state_t     nxt;
    logic       load;
    logic [7:0] load_val;
    logic       phase_done;
    logic [7:0] exp_q;

    phase_timer u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .done     (phase_done)
    );

    // The timer is reloaded on every transition; abort overrides everything.
    always_comb begin
        nxt      = state;
        load     = 1'b0;
        load_val = 8'd0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    nxt      = ERASE;
                    load     = 1'b1;
                    load_val = ERASE_LOAD;
                end
            end
            ERASE: begin
                if (phase_done) begin
                    load = 1'b1;
                    if (exp_q != 8'd0) begin
                        nxt      = EXPOSE;
                        load_val = exp_q - 8'd1;
                    end else begin
                        nxt      = CONVERT;
                        load_val = CONV_LOAD;
                    end
                end
            end
            EXPOSE: begin
                if (phase_done) begin
                    nxt      = CONVERT;
                    load     = 1'b1;
                    load_val = CONV_LOAD;
                end
            end
            CONVERT: begin
                if (phase_done) begin
                    nxt      = READ1;
                    load     = 1'b1;
                    load_val = READ_LOAD;
                end
            end
            READ1: begin
                if (phase_done) begin
                    nxt      = READ2;
                    load     = 1'b1;
                    load_val = READ_LOAD;
                end
            end
            READ2: begin
                if (phase_done) begin
                    nxt  = DONE;
                    load = 1'b1;
                end
            end
            DONE: begin
                nxt  = IDLE;
                load = 1'b1;
            end
            default: begin
                nxt  = IDLE;
                load = 1'b1;
            end
        endcase
        if (abort && state != IDLE) begin
            nxt      = IDLE;
            load     = 1'b1;
            load_val = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            exp_q      <= 8'd0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read1      <= 1'b0;
            read2      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt;
            erase      <= (nxt == ERASE);
            expose     <= (nxt == EXPOSE);
            convert    <= (nxt == CONVERT);
            read1      <= (nxt == READ1);
            read2      <= (nxt == READ2);
            busy       <= (nxt != IDLE);
            frame_done <= (nxt == DONE);
            if (state == IDLE && nxt == ERASE) begin
                exp_q <= exp_time;
            end
        end
    end

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Directed bench for pixel_seq_ctrl: frame timing, exposure skip, back-to-back,
// abort, async reset and exposure-latch behaviour against hand-computed values.
module tb_pixel_seq_ctrl;
    import pixel_seq_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] exp_time;
    logic       erase;
    logic       expose;
    logic       convert;
    logic       read1;
    logic       read2;
    logic       busy;
    logic       frame_done;
    state_t     dut_state;

    int tests_run;
    int tests_failed;

    int n_erase, n_expose, n_conv, n_r1, n_r2, n_done, n_busy, onehot_err;
    int last_erase, last_expose, first_conv, last_conv, first_r1;

    pixel_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .exp_time   (exp_time),
        .erase      (erase),
        .expose     (expose),
        .convert    (convert),
        .read1      (read1),
        .read2      (read2),
        .busy       (busy),
        .frame_done (frame_done),
        .state      (dut_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_erase = 0; n_expose = 0; n_conv = 0; n_r1 = 0; n_r2 = 0;
        n_done = 0; n_busy = 0; onehot_err = 0;
        last_erase = -1; last_expose = -1; first_conv = -1; last_conv = -1; first_r1 = -1;
    endtask

    task automatic sample(input int idx);
        if (erase) begin n_erase++; last_erase = idx; end
        if (expose) begin n_expose++; last_expose = idx; end
        if (convert) begin
            n_conv++;
            if (first_conv < 0) first_conv = idx;
            last_conv = idx;
        end
        if (read1) begin
            n_r1++;
            if (first_r1 < 0) first_r1 = idx;
        end
        if (read2) n_r2++;
        if (frame_done) n_done++;
        if (busy) n_busy++;
        if ($countones({erase, expose, convert, read1, read2}) > 1) onehot_err++;
    endtask

    // Leaves the caller on the negedge of the first ERASE cycle.
    task automatic launch(input logic [7:0] et);
        @(negedge clk);
        exp_time = et;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic observe_frame(input int max_cycles, input bit bump, input logic [7:0] bump_val);
        int  i;
        bit  seen_busy;
        seen_busy = 1'b0;
        for (i = 0; i < max_cycles; i++) begin
            sample(i);
            if (bump && expose) exp_time = bump_val;
            if (busy) seen_busy = 1'b1;
            else if (seen_busy) break;
            @(negedge clk);
        end
        check("frame_end_reached", 32'(i < max_cycles), 1);
    endtask

    initial begin
        int cnt;
        int nd;
        int last_done;
        int gaps;
        bit prev_erase;
        bit reached;

        tests_run = 0; tests_failed = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; exp_time = 8'd0;
        clear_stats();

        #2;
        check("rst_outputs", {25'd0, erase, expose, convert, read1, read2, busy, frame_done}, 0);
        check("rst_state", dut_state, IDLE);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Nominal frame, exposure 10
        clear_stats();
        launch(8'd10);
        observe_frame(400, 1'b0, 8'd0);
        check("nom_erase", n_erase, 5);
        check("nom_expose", n_expose, 10);
        check("nom_convert", n_conv, 255);
        check("nom_read1", n_r1, 2);
        check("nom_read2", n_r2, 2);
        check("nom_done", n_done, 1);
        check("nom_busy", n_busy, 275);
        check("nom_onehot", onehot_err, 0);
        check("nom_conv_after_expose", first_conv, last_expose + 1);
        check("nom_read1_after_conv", first_r1, last_conv + 1);

        // Exposure register latched at start; later exp_time changes ignored
        clear_stats();
        launch(8'd20);
        observe_frame(400, 1'b1, 8'd40);
        check("latch_expose", n_expose, 20);
        check("latch_busy", n_busy, 285);
        check("latch_onehot", onehot_err, 0);

        // start held high: one IDLE cycle between frame_done and next erase
        exp_time = 8'd3;
        @(negedge clk);
        start = 1'b1;
        nd = 0; last_done = 0; gaps = 0; prev_erase = 1'b0; onehot_err = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ($countones({erase, expose, convert, read1, read2}) > 1) onehot_err++;
            if (erase && !prev_erase && nd > 0) begin
                check("b2b_idle_gap", i - last_done - 1, 1);
                gaps++;
            end
            prev_erase = erase;
            if (frame_done) begin
                nd++;
                last_done = i;
                if (nd == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        check("b2b_frames", nd, 3);
        check("b2b_gaps", gaps, 2);
        check("b2b_onehot", onehot_err, 0);
        @(negedge clk);
        @(negedge clk);
        check("b2b_idle_after", busy, 0);

        // Abort on the 100th convert cycle
        launch(8'd5);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (convert) cnt++;
            if (cnt == 100) break;
            @(negedge clk);
        end
        check("abort_reach", cnt, 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outputs", {27'd0, erase, expose, convert, read1, read2}, 0);
        check("abort_busy", busy, 0);
        check("abort_done", frame_done, 0);
        check("abort_state", dut_state, IDLE);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (frame_done || busy) cnt++;
            @(negedge clk);
        end
        check("abort_stays_idle", cnt, 0);
        clear_stats();
        launch(8'd5);
        observe_frame(400, 1'b0, 8'd0);
        check("post_abort_convert", n_conv, 255);
        check("post_abort_done", n_done, 1);
        check("post_abort_busy", n_busy, 270);

        // Asynchronous reset during READ1
        launch(8'd0);
        reached = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (read1) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_read1_reach", reached, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_read1", read1, 0);
        check("rst_async_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (|{erase, expose, convert, read1, read2, busy, frame_done}) cnt++;
        end
        check("rst_wait_for_start", cnt, 0);

        // Zero exposure: EXPOSE skipped
        clear_stats();
        launch(8'd0);
        observe_frame(400, 1'b0, 8'd0);
        check("zero_expose", n_expose, 0);
        check("zero_conv_after_erase", first_conv, last_erase + 1);
        check("zero_busy", n_busy, 265);
        check("zero_done", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pixel_seq_ctrl.md
PIXEL_SEQ_CTRL -- requirements
Module: pixel_seq_ctrl

Interface
REQ-001 Parameter ERASE_CYCLES, default 5: cycles pixel erase is held.
REQ-002 Parameter CONV_CYCLES, default 255: cycles convert is held (one full 8-bit gray ramp).
REQ-003 Parameter READ_CYCLES, default 2: cycles each row-read strobe is held.
REQ-004 clk  in  1  clock; all logic SHALL be rising-edge triggered.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  frame request, level-sampled in IDLE.
REQ-007 abort  in  1  synchronous frame abort.
REQ-008 exp_time  in  8  exposure length in cycles, captured on accepted start.
REQ-009 erase  out  1  pixel erase.
REQ-010 expose  out  1  pixel exposure enable.
REQ-011 convert  out  1  gray-counter run / ADC compare enable.
REQ-012 read1  out  1  row-1 read; pixel row 1 drives pixData1, counter releases bus.
REQ-013 read2  out  1  row-2 read; pixel row 2 drives pixData2, counter releases bus.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-016 The FSM SHALL have states IDLE, ERASE, EXPOSE, CONVERT, READ1, READ2, DONE, in that order.
REQ-017 All outputs SHALL be registered Moore decodes of state: erase=ERASE, expose=EXPOSE, convert=CONVERT, read1=READ1, read2=READ2, frame_done=DONE.
REQ-018 IDLE with start=1 at a clock edge: SHALL enter ERASE next cycle and latch exp_time into exp_q.
REQ-019 Each timed state SHALL last exactly its length (ERASE_CYCLES, exp_q, CONV_CYCLES, READ_CYCLES, READ_CYCLES) via a phase counter cleared on every state entry.
REQ-020 exp_q=0: EXPOSE SHALL be skipped, ERASE proceeding directly to CONVERT.
REQ-021 DONE SHALL last one cycle then return to IDLE; start in DONE is ignored, so back-to-back frames have at least one IDLE cycle.
REQ-022 Frame length from first ERASE cycle through DONE SHALL be ERASE_CYCLES+exp_q+CONV_CYCLES+2*READ_CYCLES+1 cycles.
REQ-023 At most one of erase, expose, convert, read1, read2 SHALL be high in any cycle; read1 and read2 are never simultaneous.
REQ-024 read1 SHALL rise the cycle after convert falls; no overlap.
REQ-025 start and exp_time changes while busy SHALL be ignored.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE next cycle with all outputs low and no frame_done pulse; abort has priority over start and phase completion.
REQ-027 Phase counter SHALL be 8 bits and SHALL not wrap within a phase; parameters above 255 are illegal.

Reset
REQ-028 reset SHALL force state IDLE, phase counter 0, exp_q 0, and every output 0 immediately, independent of clk.
REQ-029 reset mid-frame SHALL abandon the frame; after release the FSM SHALL wait for a new start.

Structure
REQ-030 Package pixel_seq_pkg SHALL hold the state enum and default ERASE/CONV/READ constants.
REQ-031 A sub-module phase_timer (8-bit load/count-down, done flag) SHALL implement the phase counter; the FSM stays in pixel_seq_ctrl.

Verification
REQ-032 Defaults, exp_time=10, start pulse -> erase 5, expose 10, convert 255, read1 2, read2 2, frame_done 1 cycle; busy high 275 cycles.
REQ-033 exp_time=0 -> expose never rises; convert rises the cycle after erase falls; busy high 265 cycles.
REQ-034 start held high for 3 frames -> exactly one IDLE cycle between each frame_done and the next erase.
REQ-035 abort asserted at 100th convert cycle -> next cycle all outputs 0, busy 0, no frame_done; a new start runs a full frame.
REQ-036 reset asserted during READ1 -> read1 drops asynchronously; after release outputs stay 0 until start.
REQ-037 exp_time changed 20->40 during EXPOSE -> exposure remains 20 cycles; every cycle checks the one-hot output assertion.
